request_scheduler: RTL and testbench

Sequences all DHT11 transactions between the UART receive path, the sensor connection block and the UART transmit path. It buffers two-byte requests from the PC, validates command and address, and starts one sensor transaction at a time with a watchdog timeout. It also runs periodic re-reads when continuous monitoring is enabled, then hands exactly one two-byte response to the transmitter per transaction.

---
 rtl/request_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_request_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/request_scheduler.sv
// request_scheduler
// Schedules DHT11 transactions between the UART receive path, the sensor
// connection block and the UART transmit path. It holds one pending PC
// request and checks its command and address. It runs one sensor transaction
// at a time under a watchdog, and can re-read one sensor periodically in
// continuous mode. Each transaction ends with exactly one two-byte response
// sent to the transmitter.
//
// Parameters
//   PERIOD_CYCLES   cycles between continuous-mode re-reads
//   TIMEOUT_CYCLES  cycles to wait for sensor_done before answering 0xFC
//                   (must be at least 2)
//   NUM_SENSORS     valid sensor addresses are 0..NUM_SENSORS-1
//
// Ports
//   clock, reset                  system clock, synchronous active-high reset
//   rx_done/rx_command/rx_address new two-byte request from uart_rx (pulse)
//   sensor_start                  one-cycle pulse starting a sensor transaction
//   sensor_command/sensor_address request held from sensor_start to sensor_done
//   sensor_done                   one-cycle pulse, sensor result valid
//   sensor_resp_command/_value    sensor result bytes
//   tx_start                      one-cycle pulse, send tx_command/tx_value
//   tx_command/tx_value           response bytes held from tx_start to tx_done
//   tx_done                       one-cycle pulse, both bytes transmitted
//   busy                          scheduler is not idle
//   overflow                      sticky, a request was dropped
module request_scheduler #(
  parameter int unsigned PERIOD_CYCLES  = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter int unsigned NUM_SENSORS    = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_done,
  input  logic [7:0] rx_command,
  input  logic [7:0] rx_address,
  output logic       sensor_start,
  output logic [7:0] sensor_command,
  output logic [7:0] sensor_address,
  input  logic       sensor_done,
  input  logic [7:0] sensor_resp_command,
  input  logic [7:0] sensor_resp_value,
  output logic       tx_start,
  output logic [7:0] tx_command,
  output logic [7:0] tx_value,
  input  logic       tx_done,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned PERIOD_W  = (PERIOD_CYCLES  > 1) ? $clog2(PERIOD_CYCLES)  : 1;
  localparam int unsigned TIMEOUT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // FSM encoding
  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] CHECK       = 3'd1;
  localparam logic [2:0] SENSOR_REQ  = 3'd2;
  localparam logic [2:0] SENSOR_WAIT = 3'd3;
  localparam logic [2:0] TX_REQ      = 3'd4;
  localparam logic [2:0] TX_WAIT     = 3'd5;

  // Command set
  localparam logic [7:0] CMD_CONT_TEMP_ON  = 8'h03;
  localparam logic [7:0] CMD_CONT_HUM_ON   = 8'h04;
  localparam logic [7:0] CMD_CONT_TEMP_OFF = 8'h05;
  localparam logic [7:0] CMD_CONT_HUM_OFF  = 8'h06;
  localparam logic [7:0] CMD_LAST          = 8'h06;

  // Scheduler-generated response codes
  localparam logic [7:0] RESP_BAD_ADDR = 8'hFE;
  localparam logic [7:0] RESP_BAD_CMD  = 8'hFD;
  localparam logic [7:0] RESP_TIMEOUT  = 8'hFC;
  localparam logic [7:0] RESP_CONT_OFF = 8'h0A;

  logic [2:0]           state;
  logic [2:0]           nextState;

  // One-slot request buffer and the request currently being handled
  logic                 bufValid;
  logic [7:0]           bufCommand;
  logic [7:0]           bufAddress;
  logic [7:0]           curCommand;
  logic [7:0]           curAddress;

  // Continuous-mode slot
  logic                 contActive;
  logic [7:0]           contCommand;
  logic [7:0]           contAddress;
  logic [PERIOD_W-1:0]  periodCount;
  logic                 tickPending;

  logic [TIMEOUT_W-1:0] watchdog;

  // Decisions from the next-state logic
  logic                 consumeBuf;
  logic                 takeTick;
  logic                 startSensor;
  logic                 useContSlot;
  logic                 loadTx;
  logic [7:0]           txCommandNext;
  logic [7:0]           txValueNext;
  logic                 armCont;
  logic                 disarmCont;
  logic                 watchdogExpired;
  logic                 offMatches;

  // The watchdog reaches TIMEOUT_CYCLES-1 on this edge
  assign watchdogExpired = (watchdog == TIMEOUT_W'(TIMEOUT_CYCLES - 2));

  // An off command only cancels the continuous read of the same quantity
  assign offMatches =
      ((curCommand == CMD_CONT_TEMP_OFF) && (contCommand == CMD_CONT_TEMP_ON)) ||
      ((curCommand == CMD_CONT_HUM_OFF)  && (contCommand == CMD_CONT_HUM_ON));

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and transaction decisions
  always_comb begin
    nextState     = state;
    consumeBuf    = 1'b0;
    takeTick      = 1'b0;
    startSensor   = 1'b0;
    useContSlot   = 1'b0;
    loadTx        = 1'b0;
    txCommandNext = 8'h00;
    txValueNext   = 8'h00;
    armCont       = 1'b0;
    disarmCont    = 1'b0;

    case (state)
      IDLE: begin
        // PC requests take priority over periodic re-reads
        if (bufValid) begin
          consumeBuf = 1'b1;
          nextState  = CHECK;
        end else if (tickPending) begin
          takeTick    = 1'b1;
          useContSlot = 1'b1;
          startSensor = 1'b1;
          nextState   = SENSOR_REQ;
        end
      end

      CHECK: begin
        if (32'(curAddress) >= NUM_SENSORS) begin
          loadTx        = 1'b1;
          txCommandNext = RESP_BAD_ADDR;
          nextState     = TX_REQ;
        end else if (curCommand > CMD_LAST) begin
          loadTx        = 1'b1;
          txCommandNext = RESP_BAD_CMD;
          nextState     = TX_REQ;
        end else if ((curCommand == CMD_CONT_TEMP_OFF) ||
                     (curCommand == CMD_CONT_HUM_OFF)) begin
          disarmCont    = contActive && offMatches;
          loadTx        = 1'b1;
          txCommandNext = RESP_CONT_OFF;
          nextState     = TX_REQ;
        end else begin
          armCont     = (curCommand == CMD_CONT_TEMP_ON) ||
                        (curCommand == CMD_CONT_HUM_ON);
          startSensor = 1'b1;
          nextState   = SENSOR_REQ;
        end
      end

      SENSOR_REQ: begin
        nextState = SENSOR_WAIT;
      end

      SENSOR_WAIT: begin
        // A result arriving on the timeout cycle is still reported
        if (sensor_done) begin
          loadTx        = 1'b1;
          txCommandNext = sensor_resp_command;
          txValueNext   = sensor_resp_value;
          nextState     = TX_REQ;
        end else if (watchdogExpired) begin
          loadTx        = 1'b1;
          txCommandNext = RESP_TIMEOUT;
          nextState     = TX_REQ;
        end
      end

      TX_REQ: begin
        nextState = TX_WAIT;
      end

      TX_WAIT: begin
        if (tx_done) begin
          nextState = IDLE;
        end
      end

      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Request buffer: a request arriving while the slot is full and not being
  // drained this cycle is dropped
  always_ff @(posedge clock) begin
    if (reset) begin
      bufValid   <= 1'b0;
      bufCommand <= 8'h00;
      bufAddress <= 8'h00;
      overflow   <= 1'b0;
    end else begin
      if (rx_done && (!bufValid || consumeBuf)) begin
        bufValid   <= 1'b1;
        bufCommand <= rx_command;
        bufAddress <= rx_address;
      end else if (rx_done) begin
        overflow <= 1'b1;
      end else if (consumeBuf) begin
        bufValid <= 1'b0;
      end
    end
  end

  // Request under evaluation
  always_ff @(posedge clock) begin
    if (reset) begin
      curCommand <= 8'h00;
      curAddress <= 8'h00;
    end else if (consumeBuf) begin
      curCommand <= bufCommand;
      curAddress <= bufAddress;
    end
  end

  // Continuous-mode slot and period counter
  always_ff @(posedge clock) begin
    if (reset) begin
      contActive  <= 1'b0;
      contCommand <= 8'h00;
      contAddress <= 8'h00;
      periodCount <= '0;
      tickPending <= 1'b0;
    end else begin
      if (takeTick) begin
        tickPending <= 1'b0;
      end
      if (armCont) begin
        contActive  <= 1'b1;
        contCommand <= curCommand;
        contAddress <= curAddress;
        periodCount <= '0;
      end else if (disarmCont) begin
        // Drop any tick still waiting so no stale re-read follows
        contActive  <= 1'b0;
        periodCount <= '0;
        tickPending <= 1'b0;
      end else if (contActive) begin
        if (periodCount == PERIOD_W'(PERIOD_CYCLES - 1)) begin
          periodCount <= '0;
          tickPending <= 1'b1;
        end else begin
          periodCount <= periodCount + PERIOD_W'(1);
        end
      end
    end
  end

  // Sensor watchdog, restarted for every transaction
  always_ff @(posedge clock) begin
    if (reset) begin
      watchdog <= '0;
    end else if (state == SENSOR_REQ) begin
      watchdog <= '0;
    end else if (state == SENSOR_WAIT) begin
      watchdog <= watchdog + TIMEOUT_W'(1);
    end
  end

  // Sensor-side outputs; command/address only change when a transaction starts
  always_ff @(posedge clock) begin
    if (reset) begin
      sensor_start   <= 1'b0;
      sensor_command <= 8'h00;
      sensor_address <= 8'h00;
    end else begin
      sensor_start <= startSensor;
      if (startSensor) begin
        sensor_command <= useContSlot ? contCommand : curCommand;
        sensor_address <= useContSlot ? contAddress : curAddress;
      end
    end
  end

  // Transmit-side outputs and status
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_start   <= 1'b0;
      tx_command <= 8'h00;
      tx_value   <= 8'h00;
      busy       <= 1'b0;
    end else begin
      tx_start <= (state == TX_REQ);
      if (loadTx) begin
        tx_command <= txCommandNext;
        tx_value   <= txValueNext;
      end
      busy <= (nextState != IDLE);
    end
  end

endmodule

// File: tb/tb_request_scheduler.sv
// Directed bench for request_scheduler with short period/timeout parameters.
module tb_request_scheduler;

  localparam int unsigned PERIOD  = 1000;
  localparam int unsigned TIMEOUT = 100;
  localparam int unsigned NSENS   = 32;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_done;
  logic [7:0] rx_command;
  logic [7:0] rx_address;
  logic       sensor_start;
  logic [7:0] sensor_command;
  logic [7:0] sensor_address;
  logic       sensor_done;
  logic [7:0] sensor_resp_command;
  logic [7:0] sensor_resp_value;
  logic       tx_start;
  logic [7:0] tx_command;
  logic [7:0] tx_value;
  logic       tx_done;
  logic       busy;
  logic       overflow;

  request_scheduler #(
    .PERIOD_CYCLES (PERIOD),
    .TIMEOUT_CYCLES(TIMEOUT),
    .NUM_SENSORS   (NSENS)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .rx_done            (rx_done),
    .rx_command         (rx_command),
    .rx_address         (rx_address),
    .sensor_start       (sensor_start),
    .sensor_command     (sensor_command),
    .sensor_address     (sensor_address),
    .sensor_done        (sensor_done),
    .sensor_resp_command(sensor_resp_command),
    .sensor_resp_value  (sensor_resp_value),
    .tx_start           (tx_start),
    .tx_command         (tx_command),
    .tx_value           (tx_value),
    .tx_done            (tx_done),
    .busy               (busy),
    .overflow           (overflow)
  );

  always #5 clock = ~clock;

  int cyc        = 0;
  int startCount = 0;
  int compared   = 0;
  int mismatched = 0;

  always @(posedge clock) cyc++;
  always @(negedge clock) if (sensor_start === 1'b1) startCount++;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sendReq(input logic [7:0] cmd, input logic [7:0] addr);
    rx_command = cmd;
    rx_address = addr;
    rx_done    = 1'b1;
    step(1);
    rx_done    = 1'b0;
  endtask

  task automatic sensorDone(input logic [7:0] rc, input logic [7:0] rv);
    sensor_resp_command = rc;
    sensor_resp_value   = rv;
    sensor_done         = 1'b1;
    step(1);
    sensor_done         = 1'b0;
  endtask

  task automatic txDone();
    tx_done = 1'b1;
    step(1);
    tx_done = 1'b0;
  endtask

  task automatic waitSensorStart(input string tag, input int budget, output int at);
    int  i = 0;
    bit  found = 1'b0;
    while (!found && i < budget) begin
      if (sensor_start === 1'b1) found = 1'b1;
      else begin
        step(1);
        i++;
      end
    end
    check(tag, 32'(found), 32'd1);
    at = cyc;
  endtask

  task automatic waitTxStart(input string tag, input int budget);
    int  i = 0;
    bit  found = 1'b0;
    while (!found && i < budget) begin
      if (tx_start === 1'b1) found = 1'b1;
      else begin
        step(1);
        i++;
      end
    end
    check(tag, 32'(found), 32'd1);
  endtask

  // Full sensor round trip starting from the wait for sensor_start
  task automatic serviceTxn(input string tag, input logic [7:0] expCmd, input logic [7:0] expAddr,
                            input logic [7:0] rc, input logic [7:0] rv, input int budget,
                            output int at);
    waitSensorStart({tag, "_start"}, budget, at);
    check({tag, "_scmd"}, 32'(sensor_command), 32'(expCmd));
    check({tag, "_saddr"}, 32'(sensor_address), 32'(expAddr));
    step(2);
    sensorDone(rc, rv);
    waitTxStart({tag, "_txstart"}, 10);
    check({tag, "_txcmd"}, 32'(tx_command), 32'(rc));
    check({tag, "_txval"}, 32'(tx_value), 32'(rv));
    step(1);
    txDone();
  endtask

  int s0, s1, s2, s3, cnt;

  initial begin
    reset               = 1'b1;
    rx_done             = 1'b0;
    rx_command          = 8'h00;
    rx_address          = 8'h00;
    sensor_done         = 1'b0;
    sensor_resp_command = 8'h00;
    sensor_resp_value   = 8'h00;
    tx_done             = 1'b0;
    step(3);

    // Reset state
    check("rst_sensor_start", 32'(sensor_start), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_sensor_cmd", 32'(sensor_command), 32'd0);
    check("rst_tx_cmd", 32'(tx_command), 32'd0);
    reset = 1'b0;
    step(1);

    // Temperature read of sensor 0: sensor_start at N+3, tx_start 2 after done
    sendReq(8'h01, 8'h00);
    check("t1_n1_no_start", 32'(sensor_start), 32'd0);
    step(2);
    check("t1_start", 32'(sensor_start), 32'd1);
    check("t1_scmd", 32'(sensor_command), 32'h01);
    check("t1_saddr", 32'(sensor_address), 32'h00);
    check("t1_busy", 32'(busy), 32'd1);
    step(2);
    sensorDone(8'h09, 8'h19);
    check("t1_tx_early", 32'(tx_start), 32'd0);
    step(1);
    check("t1_tx_start", 32'(tx_start), 32'd1);
    check("t1_tx_cmd", 32'(tx_command), 32'h09);
    check("t1_tx_val", 32'(tx_value), 32'h19);
    step(1);
    check("t1_tx_pulse", 32'(tx_start), 32'd0);
    check("t1_tx_hold", 32'(tx_command), 32'h09);
    txDone();
    check("t1_idle", 32'(busy), 32'd0);

    // Invalid address: no sensor transaction, 0xFE at N+4
    cnt = startCount;
    sendReq(8'h01, 8'h20);
    step(3);
    check("t2_tx_start", 32'(tx_start), 32'd1);
    check("t2_tx_cmd", 32'(tx_command), 32'hFE);
    check("t2_tx_val", 32'(tx_value), 32'h00);
    txDone();

    // Invalid command: 0xFD
    sendReq(8'h07, 8'h00);
    step(3);
    check("t3_tx_start", 32'(tx_start), 32'd1);
    check("t3_tx_cmd", 32'(tx_command), 32'hFD);
    txDone();
    check("t23_no_sensor", 32'(startCount), 32'(cnt));

    // Sensor timeout: 0xFC at TIMEOUT+1 cycles after sensor_start
    sendReq(8'h01, 8'h05);
    step(2);
    check("t4_start", 32'(sensor_start), 32'd1);
    step(TIMEOUT);
    check("t4_tx_early", 32'(tx_start), 32'd0);
    step(1);
    check("t4_tx_start", 32'(tx_start), 32'd1);
    check("t4_tx_cmd", 32'(tx_command), 32'hFC);
    check("t4_tx_val", 32'(tx_value), 32'h00);
    txDone();

    // Overflow: one request buffered during SENSOR_WAIT, the next dropped
    sendReq(8'h02, 8'h01);
    step(4);
    sendReq(8'h01, 8'h03);
    check("t5_no_ovf", 32'(overflow), 32'd0);
    sendReq(8'h02, 8'h04);
    check("t5_ovf", 32'(overflow), 32'd1);
    sensorDone(8'h02, 8'h33);
    step(1);
    check("t5_tx1_start", 32'(tx_start), 32'd1);
    check("t5_tx1_val", 32'(tx_value), 32'h33);
    step(1);
    txDone();
    cnt = startCount;
    step(2);
    check("t5_buf_start", 32'(sensor_start), 32'd1);
    check("t5_buf_cmd", 32'(sensor_command), 32'h01);
    check("t5_buf_addr", 32'(sensor_address), 32'h03);
    step(2);
    sensorDone(8'h01, 8'h1A);
    step(1);
    check("t5_tx2_val", 32'(tx_value), 32'h1A);
    txDone();
    step(10);
    check("t5_dropped", 32'(startCount), 32'(cnt + 1));
    check("t5_ovf_sticky", 32'(overflow), 32'd1);

    // Continuous temperature on sensor 2
    sendReq(8'h03, 8'h02);
    serviceTxn("t6_first", 8'h03, 8'h02, 8'h01, 8'h17, 4, s0);
    serviceTxn("t6_tick1", 8'h03, 8'h02, 8'h01, 8'h18, PERIOD + 100, s1);
    serviceTxn("t6_tick2", 8'h03, 8'h02, 8'h01, 8'h19, PERIOD + 100, s2);
    check("t6_period", 32'(s2 - s1), 32'(PERIOD));

    // Humidity-off does not cancel continuous temperature but is acknowledged
    sendReq(8'h06, 8'h00);
    step(3);
    check("t6_off6_tx", 32'(tx_start), 32'd1);
    check("t6_off6_cmd", 32'(tx_command), 32'h0A);
    txDone();
    serviceTxn("t6_tick3", 8'h03, 8'h02, 8'h01, 8'h1B, PERIOD + 100, s3);
    check("t6_period_kept", 32'(s3 - s2), 32'(PERIOD));

    // Temperature-off stops the periodic reads
    sendReq(8'h05, 8'h00);
    step(3);
    check("t6_off5_tx", 32'(tx_start), 32'd1);
    check("t6_off5_cmd", 32'(tx_command), 32'h0A);
    check("t6_off5_val", 32'(tx_value), 32'h00);
    txDone();
    cnt = startCount;
    step(2 * PERIOD + 50);
    check("t6_stopped", 32'(startCount), 32'(cnt));

    // Reset during TX_WAIT, then stray handshakes are ignored
    sendReq(8'h01, 8'h00);
    step(4);
    sensorDone(8'h04, 8'h05);
    step(1);
    check("t7_tx_start", 32'(tx_start), 32'd1);
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("t7_rst_tx_start", 32'(tx_start), 32'd0);
    check("t7_rst_busy", 32'(busy), 32'd0);
    check("t7_rst_ovf", 32'(overflow), 32'd0);
    check("t7_rst_tx_cmd", 32'(tx_command), 32'd0);
    check("t7_rst_tx_val", 32'(tx_value), 32'd0);
    check("t7_rst_scmd", 32'(sensor_command), 32'd0);
    check("t7_rst_saddr", 32'(sensor_address), 32'd0);
    cnt = startCount;
    tx_done     = 1'b1;
    sensor_done = 1'b1;
    step(1);
    tx_done     = 1'b0;
    sensor_done = 1'b0;
    step(2);
    check("t7_stray_busy", 32'(busy), 32'd0);
    check("t7_stray_tx", 32'(tx_start), 32'd0);
    check("t7_stray_sensor", 32'(startCount), 32'(cnt));
    sendReq(8'h02, 8'h07);
    step(2);
    check("t7_next_start", 32'(sensor_start), 32'd1);
    check("t7_next_cmd", 32'(sensor_command), 32'h02);
    check("t7_next_addr", 32'(sensor_address), 32'h07);
    step(2);
    sensorDone(8'h02, 8'h2A);
    step(1);
    check("t7_next_tx", 32'(tx_start), 32'd1);
    check("t7_next_val", 32'(tx_value), 32'h2A);
    txDone();
    check("t7_next_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global time bound
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish, observed %0d cycles", cyc);
    $fatal(1, "bench time limit expired");
  end

endmodule
